// File: rtl/step_grid_map.sv
// Tile grid for a VGA step map: registered pixel-to-tile lookup plus a small
// write/clear engine that updates one 3-bit cell per cycle.
module step_grid_map #(
    parameter int NUM_OF_ROWS = 7,
    parameter int NUM_OF_COLS = 10,
    parameter int TILE_SHIFT  = 6
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic [10:0] tileTopLeftX,
    output logic [10:0] tileTopLeftY,
    output logic [2:0]  step_type,
    input  logic        wr_req,
    input  logic [2:0]  wr_row,
    input  logic [3:0]  wr_col,
    input  logic [2:0]  wr_type,
    output logic        wr_ack,
    input  logic        clear_req,
    output logic        busy
);

    localparam int CELLS = NUM_OF_ROWS * NUM_OF_COLS;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
    localparam logic [2:0]       FREE     = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        CLEAR = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] sweep_idx_r;
    logic [IDX_W-1:0] sweep_idx_nxt_s;
    logic [2:0]       cells_r [CELLS];

    logic             mem_we_s;
    logic [IDX_W-1:0] mem_idx_s;
    logic [2:0]       mem_data_s;
    logic             wr_ack_r;
    logic             wr_ack_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;

    logic             wr_in_range_s;
    logic [IDX_W-1:0] wr_idx_s;

    logic [10:0]      col_s;
    logic [10:0]      row_s;
    logic             in_grid_s;
    logic [IDX_W-1:0] rd_idx_s;

    logic [10:0]      tile_x_r;
    logic [10:0]      tile_y_r;
    logic [2:0]       step_type_r;

    // Decode the requested write cell; out-of-range targets never touch storage
    always_comb begin
        wr_in_range_s = (32'(wr_row) < NUM_OF_ROWS) && (32'(wr_col) < NUM_OF_COLS);
        if (wr_in_range_s) begin
            wr_idx_s = IDX_W'(32'(wr_row) * NUM_OF_COLS + 32'(wr_col));
        end else begin
            wr_idx_s = ZERO_IDX;
        end
    end

    // Control state, sweep index and registered handshake outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r     <= IDLE;
            sweep_idx_r <= ZERO_IDX;
            wr_ack_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            sweep_idx_r <= sweep_idx_nxt_s;
            wr_ack_r    <= wr_ack_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    // Next-state logic; clear has priority over a write arriving on the same cycle
    always_comb begin
        state_nxt_s     = state_r;
        sweep_idx_nxt_s = sweep_idx_r;
        mem_we_s        = 1'b0;
        mem_idx_s       = ZERO_IDX;
        mem_data_s      = FREE;
        wr_ack_nxt_s    = 1'b0;
        busy_nxt_s      = busy_r;
        case (state_r)
            IDLE: begin
                if (clear_req) begin
                    state_nxt_s     = CLEAR;
                    sweep_idx_nxt_s = ZERO_IDX;
                    busy_nxt_s      = 1'b1;
                end else if (wr_req) begin
                    state_nxt_s  = WRITE;
                    mem_we_s     = wr_in_range_s;
                    mem_idx_s    = wr_idx_s;
                    mem_data_s   = wr_type;
                    wr_ack_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITE: begin
                state_nxt_s = IDLE;
            end
            CLEAR: begin
                mem_we_s   = 1'b1;
                mem_idx_s  = sweep_idx_r;
                mem_data_s = FREE;
                if (sweep_idx_r == LAST_IDX) begin
                    state_nxt_s     = IDLE;
                    sweep_idx_nxt_s = ZERO_IDX;
                    busy_nxt_s      = 1'b0;
                end else begin
                    sweep_idx_nxt_s = sweep_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                sweep_idx_nxt_s = ZERO_IDX;
                busy_nxt_s      = 1'b0;
            end
        endcase
    end

    // Cell storage with a single write port shared by writes and the clear sweep
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < CELLS; i++) begin
                cells_r[i] <= FREE;
            end
        end else if (mem_we_s) begin
            cells_r[mem_idx_s] <= mem_data_s;
        end else begin
            cells_r[mem_idx_s] <= cells_r[mem_idx_s];
        end
    end

    // Pixel to tile decode
    always_comb begin
        col_s     = pixelX >> TILE_SHIFT;
        row_s     = pixelY >> TILE_SHIFT;
        in_grid_s = (32'(col_s) < NUM_OF_COLS) && (32'(row_s) < NUM_OF_ROWS);
        if (in_grid_s) begin
            rd_idx_s = IDX_W'(32'(row_s) * NUM_OF_COLS + 32'(col_s));
        end else begin
            rd_idx_s = ZERO_IDX;
        end
    end

    // Lookup register; reads pre-write contents when a cell is written on the same edge
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tile_x_r    <= 11'd0;
            tile_y_r    <= 11'd0;
            step_type_r <= FREE;
        end else if (in_grid_s) begin
            tile_x_r    <= col_s << TILE_SHIFT;
            tile_y_r    <= row_s << TILE_SHIFT;
            step_type_r <= cells_r[rd_idx_s];
        end else begin
            tile_x_r    <= 11'd0;
            tile_y_r    <= 11'd0;
            step_type_r <= FREE;
        end
    end

    assign tileTopLeftX = tile_x_r;
    assign tileTopLeftY = tile_y_r;
    assign step_type    = step_type_r;
    assign wr_ack       = wr_ack_r;
    assign busy         = busy_r;

endmodule
